bcd_conv_sched: RTL and testbench

BCD_CONV_SCHED -- requirements
Module: bcd_conv_sched

---
 rtl/bcd_conv_sched_pkg.sv | 21 ++
 rtl/bcd_dd_engine.sv | 54 +++++
 rtl/bcd_conv_sched.sv | 112 +++++++++++
 tb/tb_bcd_conv_sched.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_conv_sched_pkg.sv
// Shared types and constants for the shared binary-to-BCD converter.
// Holds the scheduler state encoding and the double-dabble digit adjust helper.
package bcd_conv_sched_pkg;

  localparam int DATA_W      = 8;
  localparam int BCD_DIGITS  = 3;
  localparam int CONV_CYCLES = 8;
  localparam int BCD_W       = 4 * BCD_DIGITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    RESP = 2'd2
  } state_t;

  // Add-3 correction applied to a digit before each shift.
  function automatic logic [3:0] dd_adjust(input logic [3:0] digit);
    return (digit >= 4'd5) ? (digit + 4'd3) : digit;
  endfunction

endpackage

// File: rtl/bcd_dd_engine.sv
// Iterative 8-cycle double-dabble engine: start loads the operand,
// done pulses for one cycle when bcd holds the converted value.
module bcd_dd_engine
  import bcd_conv_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] bin,
  output logic              done,
  output logic [BCD_W-1:0]  bcd
);

  localparam int CNT_W = $clog2(CONV_CYCLES);

  // Digits and remaining operand bits live in one shift register.
  logic [BCD_W+DATA_W-1:0] sh_reg;
  logic [BCD_W-1:0]        adj;
  logic [CNT_W-1:0]        step;
  logic                    running;

  always_comb begin
    adj = '0;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      adj[4*d +: 4] = dd_adjust(sh_reg[DATA_W + 4*d +: 4]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_reg  <= '0;
      step    <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sh_reg  <= {{BCD_W{1'b0}}, bin};
        step    <= '0;
        running <= 1'b1;
      end else if (running) begin
        sh_reg <= {adj, sh_reg[DATA_W-1:0]} << 1;
        step   <= step + 1'b1;
        if (step == CNT_W'(CONV_CYCLES - 1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

  assign bcd = sh_reg[BCD_W+DATA_W-1:DATA_W];

endmodule

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one BCD converter among NREQ requesters.
// Define BCD_CONV_SCHED_STATS_EN to enable the saturating conv_count counter.
module bcd_conv_sched
  import bcd_conv_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [BCD_W-1:0]       rsp_bcd,
  output logic                   busy,
  output logic [15:0]            conv_count
);

  state_t            state, state_next;
  logic [IDW-1:0]    rr_ptr;
  logic [IDW-1:0]    winner;
  logic [NREQ-1:0]   grant;
  logic              found;
  logic              accept;
  logic [DATA_W-1:0] win_data;
  logic              eng_done;
  logic [BCD_W-1:0]  eng_bcd;

  // Search starts at rr_ptr and wraps; the first asserted request wins.
  always_comb begin : arb
    logic [IDW:0] idx;
    idx    = '0;
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NREQ)) idx = idx - (IDW+1)'(NREQ);
      if (!found && req_valid[idx[IDW-1:0]]) begin
        found              = 1'b1;
        winner             = idx[IDW-1:0];
        grant[idx[IDW-1:0]] = 1'b1;
      end
    end
  end

  assign win_data = req_data[int'(winner)*DATA_W +: DATA_W];
  assign accept   = (state == IDLE) && found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)    state_next = CONV;
      CONV:    if (eng_done)  state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE) ? grant : '0;
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      rsp_id  <= '0;
      rsp_bcd <= '0;
    end else begin
      if (accept) begin
        rr_ptr <= (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
        rsp_id <= winner;
      end
      if ((state == CONV) && eng_done) rsp_bcd <= eng_bcd;
    end
  end

  bcd_dd_engine u_engine (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept),
    .bin   (win_data),
    .done  (eng_done),
    .bcd   (eng_bcd)
  );

`ifdef BCD_CONV_SCHED_STATS_EN
  logic [15:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count_q <= '0;
    else if ((state == RESP) && rsp_ready && (count_q != 16'hFFFF))
      count_q <= count_q + 16'd1;
  end

  assign conv_count = count_q;
`else
  assign conv_count = '0;
`endif

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Randomised bench for bcd_conv_sched against a transaction-level model:
// round-robin choice over pending requesters and decimal digits by division.
module tb_bcd_conv_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*8-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [IDW-1:0]    rsp_id;
  logic [11:0]       rsp_bcd;
  logic              busy;
  logic [15:0]       conv_count;

  int n_compared   = 0;
  int n_mismatched = 0;

  bit pend[NREQ];
  int opnd[NREQ];
  int m_ptr = 0;
  int m_cnt = 0;

  bcd_conv_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_bcd    (rsp_bcd),
    .busy       (busy),
    .conv_count (conv_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic int decimalBcd(input int v);
    return (v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10);
  endfunction

  function automatic int modelWinner();
    for (int k = 0; k < NREQ; k++) begin
      if (pend[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic applyStimulus();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]        = pend[i];
      req_data[8*i +: 8]  = 8'(opnd[i]);
    end
  endtask

  task automatic request(input int r, input int v);
    pend[r] = 1'b1;
    opnd[r] = v;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_rsp_valid"}, rsp_valid, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_rsp_id"}, rsp_id, 0);
    checkOutput({tag, "_rsp_bcd"}, rsp_bcd, 0);
    checkOutput({tag, "_conv_count"}, conv_count, 0);
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    req_valid = 4'b0110;
    #1;
    checkResetOutputs("reset");
    checkOutput("reset_req_ready", req_ready, 4'b0010);
    applyStimulus();
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    m_cnt = 0;
  endtask

  // One full transaction starting in IDLE at a falling edge.
  task automatic serveNext(input int hold, input bit noise);
    int w;
    int n;
    int exp_bcd;
    applyStimulus();
    #1;
    w = modelWinner();
    if (w < 0) begin
      checkOutput("idle_no_grant", req_ready, 0);
      return;
    end
    checkOutput("grant", req_ready, 32'(1 << w));
    checkOutput("busy_idle", busy, 0);
    exp_bcd = decimalBcd(opnd[w]);
    @(posedge clk);
    pend[w] = 1'b0;
    m_ptr   = (w + 1) % NREQ;
    @(negedge clk);
    if (noise) begin
      opnd[w] = $urandom_range(0, 255);
      for (int i = 0; i < NREQ; i++) begin
        if (i != w && !pend[i] && $urandom_range(0, 2) == 0) request(i, $urandom_range(0, 255));
        else if (pend[i] && $urandom_range(0, 7) == 0) pend[i] = 1'b0;
      end
    end
    applyStimulus();
    n = 0;
    #1;
    while (rsp_valid !== 1'b1 && n < 16) begin
      checkOutput("ready_while_busy", req_ready, 0);
      checkOutput("busy_conv", busy, 1);
      rsp_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("latency", n, 9);
    checkOutput("rsp_bcd", rsp_bcd, exp_bcd);
    checkOutput("rsp_id", rsp_id, w);
    rsp_ready = 1'b0;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      checkOutput("hold_valid", rsp_valid, 1);
      checkOutput("hold_bcd", rsp_bcd, exp_bcd);
      checkOutput("hold_id", rsp_id, w);
      checkOutput("hold_no_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
`ifdef BCD_CONV_SCHED_STATS_EN
    if (m_cnt < 65535) m_cnt++;
`endif
    @(negedge clk);
    checkOutput("rsp_done", rsp_valid, 0);
    checkOutput("busy_done", busy, 0);
    checkOutput("conv_count", conv_count, m_cnt);
    rsp_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  initial begin
    int w;
    applyReset();

    // Single request of the largest operand.
    request(0, 255);
    serveNext(0, 1'b0);

    // Four simultaneous requests are served in index order, then 0 before 2.
    applyReset();
    request(0, 0);
    request(1, 9);
    request(2, 99);
    request(3, 123);
    for (int k = 0; k < 4; k++) serveNext(0, 1'b0);
    request(0, 200);
    request(2, 31);
    serveNext(0, 1'b0);
    serveNext(0, 1'b0);

    // Long backpressure on the response.
    request(1, 47);
    serveNext(20, 1'b0);

    // Reset in the middle of a conversion drops it and rewinds the pointer.
    request(2, 200);
    applyStimulus();
    #1;
    w = modelWinner();
    checkOutput("mid_grant", req_ready, 32'(1 << w));
    @(posedge clk);
    pend[w] = 1'b0;
    applyStimulus();
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    m_cnt = 0;
    for (int k = 0; k < 14; k++) begin
      rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      checkOutput("no_stale_rsp", rsp_valid, 0);
      checkOutput("no_stale_busy", busy, 0);
    end
    rsp_ready = 1'b0;
    request(1, 77);
    request(3, 10);
    serveNext(0, 1'b0);
    serveNext(0, 1'b0);

    // Every operand through requester 1.
    for (int v = 0; v < 256; v++) begin
      request(1, v);
      serveNext(0, 1'b0);
    end

    // Random traffic with drops, late arrivals and backpressure.
    for (int t = 0; t < 150; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 0) request(i, $urandom_range(0, 255));
        else if (pend[i] && $urandom_range(0, 5) == 0) pend[i] = 1'b0;
      end
      if (modelWinner() < 0) request($urandom_range(0, NREQ - 1), $urandom_range(0, 255));
      serveNext($urandom_range(0, 3), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
